rv_regf_mp: RTL and testbench
=============================

Name: rv_regf_mp

Overview:
- Parametrised multi-read-port integer register file for the rv32 core family.
- Next generation of the 2R/1W core register file. Adds configurable width, depth and read-port count, optional write-to-read bypass, a per-register pending scoreboard for long-latency results, and a hardware clear sequencer that zeroes the array after reset.
- Sits between decode (reads, marks) and writeback (writes).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers. Legal values are 16 (RV32E) or 32. x0 is included in the count.
- NRD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports.
- CLR_ON_RESET, 1, 1 = run the clear sequencer after reset; 0 = ready the cycle after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_addr  in  NRD x 5  read addresses.
- rd_data  out  NRD x XLEN  read data, combinational.
- rd_pend  out  NRD x 1  addressed register has an outstanding result.
- wr_en  in  1  write enable.
- wr_addr  in  5  write address.
- wr_data  in  XLEN  write data.
- mark_en  in  1  set the pending bit for mark_addr (long-latency op issued).
- mark_addr  in  5  register to mark pending.
- flush  in  1  clear all pending bits (pipeline flush).
- ready  out  1  clear sequence complete; the file is usable.

Behaviour:
- Reset (synchronous, active-high):
  - state <= CLEAR when CLR_ON_RESET=1, else READY.
  - clear counter cnt <= 1; all pending bits <= 0.
  - ready is 0 during reset and in the first cycle after it.
  - Register contents are not touched by reset itself.
- State machine, two states:
  - CLEAR: each cycle write 0 to regf[cnt], then cnt++. When cnt == NREGS-1 is written, go to READY. This takes NREGS-1 cycles after reset deasserts; ready rises on the following edge.
  - READY: normal operation. The only exit is reset.
  - Reset asserted during CLEAR restarts the sequence at cnt=1.
- During CLEAR:
  - wr_en, mark_en and flush are ignored.
  - rd_data = 0 and rd_pend = 0 on all ports.
- x0:
  - Reads always return 0 with pend 0.
  - Writes and marks to x0 are ignored.
- Out-of-range addresses (addr >= NREGS):
  - Writes and marks are ignored.
  - Reads return 0 with pend 0.
- Write: when wr_en is high in READY, regf[wr_addr] <= wr_data and pend[wr_addr] <= 0 on the edge.
- Mark: when mark_en is high, pend[mark_addr] <= 1 on the edge.
- Write and mark to the same address in the same cycle: pend ends at 1 (a new op is outstanding); data is still written.
- Flush clears all pend bits on the edge. If flush and mark occur in the same cycle, the mark wins for mark_addr.
- Read latency is 0 cycles (combinational from rd_addr).
- BYPASS=1: when wr_en is high and wr_addr == rd_addr[i] (nonzero, in range, READY):
  - rd_data[i] = wr_data.
  - rd_pend[i] = 0, unless mark_en targets the same address in that cycle.
- BYPASS=0: the read returns the old contents and old pend until the edge.
- Multiple read ports on the same address return identical values.
- Widths: addresses are always 5 bits. For NREGS=16, bit 4 set means out of range.

Decomposition:
- The shared rv package holds:
  - u5_t and the XLEN-based data typedef;
  - the regf state enum (CLEAR, READY);
  - REG_X0 = 5'd0.
- One natural sub-module: rv_regf_scoreboard, the NREGS-bit pending vector with mark/write/flush priority and the per-port lookup.
- Array, clear sequencer and bypass mux stay in rv_regf_mp.

Test Plan:
- Clear sequence: NREGS=32; preload x5=0xDEADBEEF by force, pulse reset 1 cycle -> ready rises exactly 32 edges after reset deasserts (31 clear cycles + 1), and rd_data for x5 = 0. Repeat with CLR_ON_RESET=0 -> ready rises 1 edge after reset deasserts.
- Basic R/W with bypass: write x7=0x12345678 while rd_addr[0]=7 -> same-cycle rd_data[0]=0x12345678 with BYPASS=1, or 0 with BYPASS=0; next cycle both configs read 0x12345678.
- x0 and range: write x0=0xFFFFFFFF -> reads 0. With NREGS=16, write x20=0x55 -> ignored; reading x20 gives 0, pend 0.
- Scoreboard:
  - mark x9 -> next cycle rd_pend for x9 = 1;
  - write x9=0xA5 -> same cycle rd_pend=0 with bypass, and 0 after the edge;
  - simultaneous mark+write x9 -> pend remains 1 and data = 0xA5.
- Flush priority: mark x3 and x4, then flush + mark x4 in the same cycle -> pend x3=0, pend x4=1.
- Reset mid-clear: assert reset at clear cycle 10 -> cnt restarts at 1, ready rises 32 edges after the second reset deasserts, and writes issued during CLEAR have no effect.

Source files
------------

// File: rtl/rv_regf_mp_pkg.sv
// Shared types for the rv32 multi-port register file: address/data typedefs,
// sequencer states and the x0 constant.
package rv_regf_mp_pkg;

  localparam int XLEN_DEF = 32;

  typedef logic [4:0]          u5_t;
  typedef logic [XLEN_DEF-1:0] xword_t;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } regf_state_e;

  localparam u5_t REG_X0 = 5'd0;

  // True for a writable/readable architectural register (not x0, inside the file).
  function automatic logic addr_ok(input u5_t a, input int nregs);
    return (a != REG_X0) && (int'(a) < nregs);
  endfunction

endpackage

// File: rtl/rv_regf_scoreboard.sv
// Per-register pending bits for long-latency results, with mark > flush > write
// priority, plus a raw lookup for every read port.
module rv_regf_scoreboard
  import rv_regf_mp_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int NRD   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active,
  input  logic             wr_en,
  input  u5_t              wr_addr,
  input  logic             mark_en,
  input  u5_t              mark_addr,
  input  logic             flush,
  input  logic [NRD*5-1:0] rd_addr,
  output logic [NRD-1:0]   pend_lkp
);

  localparam int AW = $clog2(NREGS);

  logic [NREGS-1:0] pend_reg;
  logic [NREGS-1:0] pend_next;
  logic             wr_hit;
  logic             mark_hit;
  logic             flush_hit;

  assign wr_hit    = active && wr_en   && addr_ok(wr_addr, NREGS);
  assign mark_hit  = active && mark_en && addr_ok(mark_addr, NREGS);
  assign flush_hit = active && flush;

  // Later assignments win: a fresh mark overrides both flush and retiring write.
  always_comb begin
    pend_next = pend_reg;
    if (flush_hit) pend_next = '0;
    if (wr_hit)    pend_next[wr_addr[AW-1:0]] = 1'b0;
    if (mark_hit)  pend_next[mark_addr[AW-1:0]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) pend_reg <= '0;
    else       pend_reg <= pend_next;
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_lkp
    u5_t a;
    assign a            = rd_addr[gi*5 +: 5];
    assign pend_lkp[gi] = addr_ok(a, NREGS) ? pend_reg[a[AW-1:0]] : 1'b0;
  end

endmodule

// File: rtl/rv_regf_mp.sv
// Parametrised multi-read-port integer register file with write bypass,
// pending scoreboard and a post-reset clear sequencer.
module rv_regf_mp
  import rv_regf_mp_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int NREGS        = 32,
  parameter int NRD          = 2,
  parameter bit BYPASS       = 1'b1,
  parameter bit CLR_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*5-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_pend,
  input  logic                wr_en,
  input  logic [4:0]          wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                mark_en,
  input  logic [4:0]          mark_addr,
  input  logic                flush,
  output logic                ready
);

  localparam int  AW       = $clog2(NREGS);
  localparam u5_t LAST_IDX = u5_t'(NREGS - 1);

  regf_state_e       state_reg, state_next;
  u5_t               cnt_reg, cnt_next;
  logic              ready_reg;
  logic              clr_we;
  logic              active;
  logic              wr_hit;
  logic              mark_hit;
  logic [NRD-1:0]    sb_pend;
  logic [XLEN-1:0]   regf [NREGS];

  assign active   = (state_reg == READY);
  assign wr_hit   = active && wr_en   && addr_ok(wr_addr, NREGS);
  assign mark_hit = active && mark_en && addr_ok(mark_addr, NREGS);
  assign ready    = ready_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    clr_we     = 1'b0;
    case (state_reg)
      CLEAR: begin
        clr_we   = 1'b1;
        cnt_next = cnt_reg + 5'd1;
        if (cnt_reg == LAST_IDX) state_next = READY;
      end
      default: ;
    endcase
  end

  // ready lags the state by one edge so it is low in the first cycle after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= CLR_ON_RESET ? CLEAR : READY;
      cnt_reg   <= 5'd1;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ready_reg <= (state_reg == READY);
    end
  end

  // Contents survive reset; only the sequencer zeroes them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clr_we)      regf[cnt_reg[AW-1:0]] <= '0;
      else if (wr_hit) regf[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  rv_regf_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .active    (active),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .mark_en   (mark_en),
    .mark_addr (mark_addr),
    .flush     (flush),
    .rd_addr   (rd_addr),
    .pend_lkp  (sb_pend)
  );

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    u5_t  a;
    logic ok;
    logic byp;
    assign a   = rd_addr[gi*5 +: 5];
    assign ok  = active && addr_ok(a, NREGS);
    assign byp = BYPASS && wr_hit && (wr_addr == a);
    assign rd_data[gi*XLEN +: XLEN] = !ok ? '0 : (byp ? wr_data : regf[a[AW-1:0]]);
    assign rd_pend[gi] = !ok ? 1'b0 : (byp ? (mark_hit && (mark_addr == a)) : sb_pend[gi]);
  end

endmodule

// File: tb/tb_rv_regf_mp.sv
// Directed bench: default configuration (dut_a) alongside an RV32E,
// no-bypass, no-clear variant (dut_b), both driven by the same stimulus.
module tb_rv_regf_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        mark_en;
  logic [4:0]  mark_addr;
  logic        flush;
  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_pend_a, rd_pend_b;
  logic        ready_a, ready_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rv_regf_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1'b1), .CLR_ON_RESET(1'b1)) dut_a (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_pend(rd_pend_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .mark_en(mark_en),
    .mark_addr(mark_addr), .flush(flush), .ready(ready_a)
  );

  rv_regf_mp #(.XLEN(32), .NREGS(16), .NRD(2), .BYPASS(1'b0), .CLR_ON_RESET(1'b0)) dut_b (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_pend(rd_pend_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .mark_en(mark_en),
    .mark_addr(mark_addr), .flush(flush), .ready(ready_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic me, input logic [4:0] ma, input logic fl,
                       input logic [4:0] a0, input logic [4:0] a1);
    wr_en = we; wr_addr = wa; wr_data = wd;
    mark_en = me; mark_addr = ma; flush = fl;
    rd_addr = {a1, a0};
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, rd_addr[4:0], rd_addr[9:5]);
  endtask

  // Pulse reset for one edge, then count edges until dut_a reports ready.
  task automatic reset_and_wait(output int n_a, output int n_b);
    @(negedge clk); reset = 1'b1; idle();
    @(negedge clk); reset = 1'b0;
    n_a = 0; n_b = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      n_a++;
      if (ready_b && n_b == 0) n_b = n_a;
      if (ready_a) break;
    end
  endtask

  int na, nb;

  initial begin
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready_a", {31'b0, ready_a}, 32'd0);
    check("reset_ready_b", {31'b0, ready_b}, 32'd0);

    reset_and_wait(na, nb);
    check("clr_latency_a", na, 32'd32);
    check("clr_latency_b", nb, 32'd1);

    // Preload x5, then reset again: dut_a clears it, dut_b keeps it.
    @(negedge clk); drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 5'd5);
    @(negedge clk); idle(); #1;
    check("preload_x5_a", rd_data_a[63:32], 32'hDEADBEEF);
    check("preload_x5_b", rd_data_b[63:32], 32'hDEADBEEF);
    reset_and_wait(na, nb);
    check("clr_latency2_a", na, 32'd32);
    @(negedge clk); #1;
    check("cleared_x5_a", rd_data_a[63:32], 32'h0);
    check("kept_x5_b", rd_data_b[63:32], 32'hDEADBEEF);

    // Bypass versus old contents.
    @(negedge clk); drive(1'b1, 5'd7, 32'h11111111, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7);
    @(negedge clk); drive(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7); #1;
    check("byp_x7_a", rd_data_a[31:0], 32'h12345678);
    check("nobyp_x7_b", rd_data_b[31:0], 32'h11111111);
    check("ports_same_a", rd_data_a[63:32], 32'h12345678);
    @(negedge clk); idle(); #1;
    check("x7_after_a", rd_data_a[31:0], 32'h12345678);
    check("x7_after_b", rd_data_b[31:0], 32'h12345678);

    // x0 and out-of-range (x20 is valid only in the 32-entry file).
    @(negedge clk); drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0); #1;
    check("x0_byp_a", rd_data_a[31:0], 32'h0);
    @(negedge clk); drive(1'b1, 5'd20, 32'h55, 1'b1, 5'd20, 1'b0, 5'd0, 5'd20); #1;
    check("x0_after_a", rd_data_a[31:0], 32'h0);
    check("x0_pend_a", {31'b0, rd_pend_a[0]}, 32'd0);
    @(negedge clk); idle(); #1;
    check("x20_a", rd_data_a[63:32], 32'h55);
    check("x20_pend_a", {31'b0, rd_pend_a[1]}, 32'd1);
    check("x20_b", rd_data_b[63:32], 32'h0);
    check("x20_pend_b", {31'b0, rd_pend_b[1]}, 32'd0);

    // Scoreboard on x9.
    @(negedge clk); drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd9);
    @(negedge clk); idle(); #1;
    check("mark_x9_a", {31'b0, rd_pend_a[0]}, 32'd1);
    check("mark_x9_b", {31'b0, rd_pend_b[0]}, 32'd1);
    @(negedge clk); drive(1'b1, 5'd9, 32'h5A, 1'b0, 5'd0, 1'b0, 5'd9, 5'd9); #1;
    check("wr_x9_pend_byp_a", {31'b0, rd_pend_a[0]}, 32'd0);
    check("wr_x9_pend_old_b", {31'b0, rd_pend_b[0]}, 32'd1);
    @(negedge clk); idle(); #1;
    check("wr_x9_pend_a", {31'b0, rd_pend_a[0]}, 32'd0);
    check("wr_x9_pend_b", {31'b0, rd_pend_b[0]}, 32'd0);
    @(negedge clk); drive(1'b1, 5'd9, 32'hA5, 1'b1, 5'd9, 1'b0, 5'd9, 5'd9); #1;
    check("mw_x9_byp_pend_a", {31'b0, rd_pend_a[0]}, 32'd1);
    check("mw_x9_byp_data_a", rd_data_a[31:0], 32'hA5);
    check("mw_x9_old_data_b", rd_data_b[31:0], 32'h5A);
    @(negedge clk); idle(); #1;
    check("mw_x9_pend_a", {31'b0, rd_pend_a[0]}, 32'd1);
    check("mw_x9_data_a", rd_data_a[31:0], 32'hA5);
    check("mw_x9_pend_b", {31'b0, rd_pend_b[0]}, 32'd1);
    check("mw_x9_data_b", rd_data_b[31:0], 32'hA5);

    // Flush with a simultaneous mark.
    @(negedge clk); drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd4);
    @(negedge clk); drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd3, 5'd4);
    @(negedge clk); drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd3, 5'd4);
    @(negedge clk); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd4); #1;
    check("flush_x3_a", {31'b0, rd_pend_a[0]}, 32'd0);
    check("flush_x4_a", {31'b0, rd_pend_a[1]}, 32'd1);
    check("flush_x3_b", {31'b0, rd_pend_b[0]}, 32'd0);
    check("flush_x4_b", {31'b0, rd_pend_b[1]}, 32'd1);
    @(negedge clk); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd9); #1;
    check("flush_x9_a", {31'b0, rd_pend_a[0]}, 32'd0);

    // Reset during clear; writes issued mid-clear must not land.
    @(negedge clk); reset = 1'b1; idle();
    @(negedge clk); reset = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    na = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      na++;
      if (ready_a) break;
      @(negedge clk);
      if (na == 4) begin
        drive(1'b1, 5'd2, 32'h77, 1'b1, 5'd2, 1'b0, 5'd20, 5'd2); #1;
        check("clear_rd_x20_a", rd_data_a[31:0], 32'h0);
        check("clear_pend_x2_a", {31'b0, rd_pend_a[1]}, 32'd0);
      end else begin
        idle();
      end
    end
    check("clr_restart_latency_a", na, 32'd32);
    @(negedge clk); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd2, 5'd20); #1;
    check("clear_wr_x2_a", rd_data_a[31:0], 32'h0);
    check("clear_mark_x2_a", {31'b0, rd_pend_a[0]}, 32'd0);
    check("x20_recleared_a", rd_data_a[63:32], 32'h0);
    check("ready_wr_x2_b", rd_data_b[31:0], 32'h77);
    check("ready_mark_x2_b", {31'b0, rd_pend_b[0]}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
